// File: rtl/midi_note_parser.sv
// MIDI byte-stream parser: turns Note On/Off traffic (with running status) into registered note events.
// Define MIDI_CHANNEL_FILTER_EN to accept only notes on channel CHANNEL; otherwise all channels are accepted.
module midi_note_parser #(
   parameter int CHANNEL           = 0,
   parameter int DATA_WIDTH        = 7,
   parameter int STRAY_COUNT_WIDTH = 8
) (
   input  logic                         clock_50_000_000,
   input  logic                         reset_l,
   input  logic [7:0]                   rx_byte,
   input  logic                         rx_valid,
   output logic                         note_status,
   output logic [DATA_WIDTH-1:0]        note_number,
   output logic [DATA_WIDTH-1:0]        note_velocity,
   output logic                         note_ready,
   output logic [STRAY_COUNT_WIDTH-1:0] stray_count
);

   typedef enum logic [1:0] {IDLE, NOTE_D1, NOTE_D2, SKIP} state_t;
   typedef enum logic [2:0] {RS_NONE, RS_OFF, RS_ON, RS_SKIP1, RS_SKIP2} run_t;

   state_t                       state_q, state_d;
   run_t                         run_q, run_d;
   logic [1:0]                   remain_q, remain_d;
   logic [DATA_WIDTH-1:0]        latch_q, latch_d;
   logic                         status_q, status_d;
   logic [DATA_WIDTH-1:0]        number_q, number_d;
   logic [DATA_WIDTH-1:0]        velocity_q, velocity_d;
   logic                         ready_q, ready_d;
   logic [STRAY_COUNT_WIDTH-1:0] stray_q, stray_d;

   logic                  is_realtime;
   logic                  chan_ok;
   logic                  vel_on;
   logic [DATA_WIDTH-1:0] data_val;

`ifdef MIDI_CHANNEL_FILTER_EN
   logic [3:0] chan_q, chan_d;
   assign chan_ok = (chan_q == 4'(CHANNEL));
`else
   assign chan_ok = 1'b1;
`endif

   assign is_realtime = (rx_byte[7:3] == 5'b11111);
   assign data_val    = DATA_WIDTH'(rx_byte[6:0]);
   assign vel_on      = (run_q == RS_ON) && (rx_byte[6:0] != 7'd0);

   always_comb begin
      state_d    = state_q;
      run_d      = run_q;
      remain_d   = remain_q;
      latch_d    = latch_q;
      status_d   = status_q;
      number_d   = number_q;
      velocity_d = velocity_q;
      ready_d    = 1'b0;
      stray_d    = stray_q;
`ifdef MIDI_CHANNEL_FILTER_EN
      chan_d     = chan_q;
`endif
      if (rx_valid && !is_realtime) begin
         if (rx_byte[7]) begin
            // Any status byte aborts whatever message was in progress.
            case (rx_byte[7:4])
               4'h8, 4'h9: begin
                  run_d   = (rx_byte[4]) ? RS_ON : RS_OFF;
                  state_d = NOTE_D1;
`ifdef MIDI_CHANNEL_FILTER_EN
                  chan_d  = rx_byte[3:0];
`endif
               end
               4'hA, 4'hB, 4'hE: begin
                  run_d    = RS_SKIP2;
                  state_d  = SKIP;
                  remain_d = 2'd2;
               end
               4'hC, 4'hD: begin
                  run_d    = RS_SKIP1;
                  state_d  = SKIP;
                  remain_d = 2'd1;
               end
               default: begin
                  run_d   = RS_NONE;
                  state_d = IDLE;
               end
            endcase
         end else begin
            case (state_q)
               IDLE: begin
                  case (run_q)
                     RS_OFF, RS_ON: begin
                        latch_d = data_val;
                        state_d = NOTE_D2;
                     end
                     RS_SKIP2: begin
                        state_d  = SKIP;
                        remain_d = 2'd1;
                     end
                     RS_SKIP1: state_d = IDLE;
                     default: begin
                        if (stray_q != {STRAY_COUNT_WIDTH{1'b1}}) begin
                           stray_d = stray_q + STRAY_COUNT_WIDTH'(1);
                        end
                     end
                  endcase
               end
               NOTE_D1: begin
                  latch_d = data_val;
                  state_d = NOTE_D2;
               end
               NOTE_D2: begin
                  state_d = IDLE;
                  if (chan_ok) begin
                     status_d   = vel_on;
                     number_d   = latch_q;
                     velocity_d = vel_on ? data_val : '0;
                     ready_d    = 1'b1;
                  end
               end
               default: begin
                  remain_d = remain_q - 2'd1;
                  if (remain_q <= 2'd1) begin
                     state_d = IDLE;
                  end
               end
            endcase
         end
      end
   end

   always_ff @(posedge clock_50_000_000) begin
      if (!reset_l) begin
         state_q    <= IDLE;
         run_q      <= RS_NONE;
         remain_q   <= 2'd0;
         latch_q    <= '0;
         status_q   <= 1'b0;
         number_q   <= '0;
         velocity_q <= '0;
         ready_q    <= 1'b0;
         stray_q    <= '0;
`ifdef MIDI_CHANNEL_FILTER_EN
         chan_q     <= 4'd0;
`endif
      end else begin
         state_q    <= state_d;
         run_q      <= run_d;
         remain_q   <= remain_d;
         latch_q    <= latch_d;
         status_q   <= status_d;
         number_q   <= number_d;
         velocity_q <= velocity_d;
         ready_q    <= ready_d;
         stray_q    <= stray_d;
`ifdef MIDI_CHANNEL_FILTER_EN
         chan_q     <= chan_d;
`endif
      end
   end

   assign note_status   = status_q;
   assign note_number   = number_q;
   assign note_velocity = velocity_q;
   assign note_ready    = ready_q;
   assign stray_count   = stray_q;

endmodule

// File: tb/tb_midi_note_parser.sv
// Directed self-checking bench for midi_note_parser; filter cases follow MIDI_CHANNEL_FILTER_EN.
module tb_midi_note_parser;

   logic       clock_50_000_000;
   logic       reset_l;
   logic [7:0] rx_byte;
   logic       rx_valid;
   logic       note_status;
   logic [6:0] note_number;
   logic [6:0] note_velocity;
   logic       note_ready;
   logic [7:0] stray_count;

   int total;
   int bad;
   int pulses;

   midi_note_parser #(
      .CHANNEL(2),
      .DATA_WIDTH(7),
      .STRAY_COUNT_WIDTH(8)
   ) dut (
      .clock_50_000_000(clock_50_000_000),
      .reset_l(reset_l),
      .rx_byte(rx_byte),
      .rx_valid(rx_valid),
      .note_status(note_status),
      .note_number(note_number),
      .note_velocity(note_velocity),
      .note_ready(note_ready),
      .stray_count(stray_count)
   );

   initial clock_50_000_000 = 1'b0;
   always #10 clock_50_000_000 = ~clock_50_000_000;

   // Count every note_ready pulse, sampled shortly after each rising edge.
   always @(posedge clock_50_000_000) begin
      #2;
      if (note_ready) pulses = pulses + 1;
   end

   initial begin
      #5ms;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   // Drive one byte for one cycle; returns at the following falling edge.
   task automatic applyStimulus(input logic [7:0] b);
      rx_byte  = b;
      rx_valid = 1'b1;
      @(negedge clock_50_000_000);
   endtask

   task automatic idleCycles(input int n);
      rx_valid = 1'b0;
      rx_byte  = 8'h00;
      for (int i = 0; i < n; i++) @(negedge clock_50_000_000);
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      total = total + 1;
      assert (observed === expected)
      else begin
         bad = bad + 1;
         $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
   endtask

   task automatic checkEvent(input string tag, input logic st, input logic [6:0] num, input logic [6:0] vel);
      checkOutput({tag, "_ready"}, 32'(note_ready), 32'd1);
      checkOutput({tag, "_status"}, 32'(note_status), 32'(st));
      checkOutput({tag, "_number"}, 32'(note_number), 32'(num));
      checkOutput({tag, "_velocity"}, 32'(note_velocity), 32'(vel));
   endtask

   initial begin
      total    = 0;
      bad      = 0;
      pulses   = 0;
      reset_l  = 1'b0;
      rx_valid = 1'b0;
      rx_byte  = 8'h00;

      // Reset state and the reset-release cycle.
      @(negedge clock_50_000_000);
      @(negedge clock_50_000_000);
      checkOutput("rst_ready", 32'(note_ready), 32'd0);
      checkOutput("rst_status", 32'(note_status), 32'd0);
      checkOutput("rst_number", 32'(note_number), 32'd0);
      checkOutput("rst_velocity", 32'(note_velocity), 32'd0);
      checkOutput("rst_stray", 32'(stray_count), 32'd0);
      reset_l = 1'b1;
      @(negedge clock_50_000_000);
      checkOutput("release_ready", 32'(note_ready), 32'd0);

      // Basic Note On.
      pulses = 0;
      applyStimulus(8'h90);
      applyStimulus(8'h3C);
      checkOutput("on_early", 32'(note_ready), 32'd0);
      applyStimulus(8'h64);
      checkEvent("on", 1'b1, 7'h3C, 7'h64);
      idleCycles(1);
      checkOutput("on_after", 32'(note_ready), 32'd0);
      checkOutput("on_hold_number", 32'(note_number), 32'h3C);
      idleCycles(2);
      checkOutput("on_pulses", 32'(pulses), 32'd1);

      // Running status, back-to-back, velocity 0 becomes Note Off.
      pulses = 0;
      applyStimulus(8'h90);
      applyStimulus(8'h40);
      applyStimulus(8'h50);
      checkEvent("rs1", 1'b1, 7'h40, 7'h50);
      applyStimulus(8'h43);
      checkOutput("rs_gap", 32'(note_ready), 32'd0);
      applyStimulus(8'h00);
      checkEvent("rs2", 1'b0, 7'h43, 7'h00);
      idleCycles(3);
      checkOutput("rs_pulses", 32'(pulses), 32'd2);

      // Realtime bytes interleaved inside a Note Off.
      pulses = 0;
      applyStimulus(8'h80);
      applyStimulus(8'hF8);
      applyStimulus(8'h3C);
      applyStimulus(8'hFE);
      checkOutput("rt_early", 32'(note_ready), 32'd0);
      applyStimulus(8'h20);
      checkEvent("rt", 1'b0, 7'h3C, 7'h00);
      idleCycles(3);
      checkOutput("rt_pulses", 32'(pulses), 32'd1);

      // Control change plus running-status skip data.
      pulses = 0;
      applyStimulus(8'hB0);
      applyStimulus(8'h07);
      applyStimulus(8'h7F);
      applyStimulus(8'h10);
      idleCycles(3);
      checkOutput("cc_pulses", 32'(pulses), 32'd0);
      checkOutput("cc_stray", 32'(stray_count), 32'd0);
      checkOutput("cc_hold_number", 32'(note_number), 32'h3C);

      // Program change: running skip-1 consumes each following byte.
      applyStimulus(8'hC0);
      applyStimulus(8'h05);
      applyStimulus(8'h06);
      idleCycles(2);
      checkOutput("pc_stray", 32'(stray_count), 32'd0);

      // Aborted note: status byte mid-message, then SysEx payload counts as stray.
      pulses = 0;
      applyStimulus(8'h90);
      applyStimulus(8'h3D);
      applyStimulus(8'hF0);
      applyStimulus(8'h01);
      applyStimulus(8'h02);
      applyStimulus(8'hF7);
      applyStimulus(8'h05);
      idleCycles(2);
      checkOutput("sysex_stray", 32'(stray_count), 32'd3);
      checkOutput("sysex_pulses", 32'(pulses), 32'd0);

      // Stray counter saturation.
      for (int i = 0; i < 300; i++) applyStimulus(8'h11);
      idleCycles(1);
      checkOutput("stray_sat", 32'(stray_count), 32'hFF);

      // Reset in the middle of a message.
      pulses = 0;
      applyStimulus(8'h90);
      applyStimulus(8'h3C);
      rx_valid = 1'b0;
      reset_l  = 1'b0;
      @(negedge clock_50_000_000);
      checkOutput("mid_rst_number", 32'(note_number), 32'd0);
      checkOutput("mid_rst_status", 32'(note_status), 32'd0);
      checkOutput("mid_rst_stray", 32'(stray_count), 32'd0);
      reset_l = 1'b1;
      @(negedge clock_50_000_000);
      checkOutput("mid_rel_ready", 32'(note_ready), 32'd0);
      applyStimulus(8'h45);
      idleCycles(2);
      checkOutput("mid_stray", 32'(stray_count), 32'd1);
      checkOutput("mid_pulses", 32'(pulses), 32'd0);

      // Channel 1 is filtered when the filter is built in, accepted in omni mode.
      pulses = 0;
      applyStimulus(8'h91);
      applyStimulus(8'h3C);
      applyStimulus(8'h64);
      idleCycles(2);
`ifdef MIDI_CHANNEL_FILTER_EN
      checkOutput("ch1_pulses", 32'(pulses), 32'd0);
      checkOutput("ch1_number", 32'(note_number), 32'd0);
      checkOutput("ch1_stray", 32'(stray_count), 32'd1);
`else
      checkOutput("ch1_pulses", 32'(pulses), 32'd1);
      checkOutput("ch1_number", 32'(note_number), 32'h3C);
      checkOutput("ch1_velocity", 32'(note_velocity), 32'h64);
`endif

      pulses = 0;
      applyStimulus(8'h92);
      applyStimulus(8'h3B);
      applyStimulus(8'h64);
      checkEvent("ch2", 1'b1, 7'h3B, 7'h64);
      idleCycles(2);
      checkOutput("ch2_pulses", 32'(pulses), 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
